imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate sign-extender in the 64-bit datapath. It accepts one instruction word per handshake plus a format select, and extracts and extends the immediate for one of six formats. Branch offsets can optionally be scaled. Results pass through a DEPTH-entry skid FIFO with valid/ready on both sides, so the decode stage can stall independently of the register-read stage.

Parameters:
DATA_W, 64, output immediate width; legal values 32 or 64.
DEPTH, 2, skid FIFO entries; power of two, >=2.
ERR_CNT_W, 8, width of the saturating illegal-format counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents instr/fmt
in_ready  output  1  block can accept; equals (count != DEPTH)
instr  input  32  instruction word
fmt  input  3  format select (see Behaviour)
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
imm  output  DATA_W  extended immediate of head entry
out_err  output  1  head entry came from an illegal fmt/width combination
err_cnt  output  ERR_CNT_W  saturating count of accepted illegal entries

Behaviour:
- Single clock (clk); reset is synchronous and active-high. Reset values: out_valid=0, imm=0, out_err=0, err_cnt=0, count=0, pointers=0; in_ready=1 in the cycle after reset deasserts.
- Push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the rising edge.
- Latency: a push at edge N gives out_valid=1 after edge N (one cycle) if the FIFO was empty. Input is never combinationally forwarded to output.
- Format decode, computed at push time:
  - 0 DADDR9: instr[20:12], sign-extended.
  - 1 COND19: instr[23:5], sign-extended.
  - 2 BR26: instr[25:0], sign-extended.
  - 3 IMM12S: instr[21:10], sign-extended.
  - 4 IMM12Z: instr[21:10], zero-extended.
  - 5 MOV16: instr[20:5] zero-extended, shifted left by 16*instr[22:21].
  - 6, 7: illegal.
  - MOV16 with DATA_W=32 and instr[22]=1: illegal.
- Illegal entries store imm=0 and out_err=1. err_cnt increments once per illegal push and saturates at all-ones.
- The FIFO is circular. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Full: in_ready=0, so no push is possible and in_valid is ignored.
  - Empty: out_valid=0 and imm holds its last value. Benches check imm only when out_valid=1.
- While out_valid=1 and out_ready=0, imm and out_err are held stable.
- Reset mid-operation flushes every entry, with no drain. A push presented in the reset cycle is dropped.
- Upstream must hold instr/fmt stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro IMM_BR_SHIFT_EN.
- Defined: COND19 and BR26 results are shifted left by 2 (byte offset) after sign extension; the upper bits still reflect the sign.
- Undefined: word offsets are output unshifted. All other formats are identical in both builds.

Decomposition:
- Shared package imm_pkg holds:
  - the fmt_e enum (FMT_DADDR9=0 … FMT_MOV16=5);
  - field constants for the LSB and width of each format;
  - the fifo entry struct {imm, err}.
- One sub-module is natural: imm_extract. It is purely combinational (instr, fmt -> imm, err) and parametrised by DATA_W. The FIFO/handshake lives in imm_gen_pipe.

Test Plan:
- Reset, then push instr=0x001FF000, fmt=0 with out_ready=1 -> one cycle later out_valid=1, imm=0xFFFF_FFFF_FFFF_FFFF, out_err=0.
- Push instr=0x00800000, fmt=1 -> imm=0xFFFF_FFFF_FFFC_0000. With IMM_BR_SHIFT_EN defined -> 0xFFFF_FFFF_FFF0_0000.
- Push instr=0x00200000 with fmt=3, then fmt=4 -> imm=0xFFFF_FFFF_FFFF_F800, then 0x0000_0000_0000_0800. Order is preserved.
- Push instr=0x005579A0, fmt=5 -> imm=0x0000_ABCD_0000_0000. Push fmt=6 three times -> imm=0, out_err=1, err_cnt=3.
- Hold out_ready=0 and push DEPTH entries -> in_ready=0 after the DEPTH-th push, and the head imm is stable. Raise out_ready with in_valid=1 -> push and pop in the same cycle with count constant; the data stream matches input order, including pointer wrap.
- Fill two entries, assert reset for one cycle with in_valid=1 -> out_valid=0, err_cnt=0, in_ready=1 after reset, and the pushed word is not output.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types, field positions and helpers for the immediate pipeline.
// Build option: IMM_BR_SHIFT_EN scales COND19/BR26 offsets to bytes.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_DADDR9 = 3'd0,
      FMT_COND19 = 3'd1,
      FMT_BR26   = 3'd2,
      FMT_IMM12S = 3'd3,
      FMT_IMM12Z = 3'd4,
      FMT_MOV16  = 3'd5
   } fmt_e;

   localparam int unsigned D9_LSB  = 12;
   localparam int unsigned D9_W    = 9;
   localparam int unsigned C19_LSB = 5;
   localparam int unsigned C19_W   = 19;
   localparam int unsigned B26_LSB = 0;
   localparam int unsigned B26_W   = 26;
   localparam int unsigned I12_LSB = 10;
   localparam int unsigned I12_W   = 12;
   localparam int unsigned M16_LSB = 5;
   localparam int unsigned M16_W   = 16;
   localparam int unsigned HW_LSB  = 21;

`ifdef IMM_BR_SHIFT_EN
   localparam int unsigned BR_SH = 2;
`else
   localparam int unsigned BR_SH = 0;
`endif

   typedef struct packed {
      logic [63:0] imm;
      logic        err;
   } fifo_ent_t;

   function automatic logic [31:0] field(
      input logic [31:0] v,
      input int unsigned lsb,
      input int unsigned w
   );
      return (v >> lsb) & ((32'd1 << w) - 32'd1);
   endfunction

   // Park the field's top bit at bit 63, then arithmetic-shift back down.
   function automatic logic [63:0] sext(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [63:0] t;
      t = {32'b0, v} << (64 - w);
      return $unsigned($signed(t) >>> (64 - w));
   endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extractor: instr/fmt -> extended imm plus
// illegal flag. Branch scaling is set by IMM_BR_SHIFT_EN.
module imm_extract
   import imm_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       instr,
   input  logic [2:0]        fmt,
   output logic [DATA_W-1:0] imm,
   output logic              err
);

   logic [63:0] imm64;
   logic [1:0]  hw;

   always_comb begin
      imm64 = '0;
      err   = 1'b0;
      hw    = instr[HW_LSB +: 2];
      case (fmt)
         FMT_DADDR9: imm64 = sext(field(instr, D9_LSB, D9_W), D9_W);
         FMT_COND19: imm64 = sext(field(instr, C19_LSB, C19_W), C19_W) << BR_SH;
         FMT_BR26:   imm64 = sext(field(instr, B26_LSB, B26_W), B26_W) << BR_SH;
         FMT_IMM12S: imm64 = sext(field(instr, I12_LSB, I12_W), I12_W);
         FMT_IMM12Z: imm64 = {32'b0, field(instr, I12_LSB, I12_W)};
         FMT_MOV16: begin
            imm64 = {32'b0, field(instr, M16_LSB, M16_W)} << {hw, 4'b0000};
            // Upper halfword positions do not exist in a 32-bit datapath.
            if (DATA_W == 32 && hw[1]) err = 1'b1;
         end
         default: err = 1'b1;
      endcase
      if (err) imm64 = '0;
   end

   assign imm = imm64[DATA_W-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a DEPTH-entry circular skid FIFO.
// Build option: IMM_BR_SHIFT_EN (see imm_pkg).
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instr,
   input  logic [2:0]           fmt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    imm,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   fifo_ent_t             mem_q [DEPTH];
   fifo_ent_t             mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic [DATA_W-1:0]     ext_imm;
   logic                  ext_err;
   fifo_ent_t             ent;
   logic                  push, pop;

   imm_extract #(.DATA_W(DATA_W)) u_extract (
      .instr (instr),
      .fmt   (fmt),
      .imm   (ext_imm),
      .err   (ext_err)
   );

   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign imm     = mem_q[rd_ptr_q].imm[DATA_W-1:0];
   assign out_err = mem_q[rd_ptr_q].err;
   assign err_cnt = err_cnt_q;

   always_comb begin
      ent.imm   = 64'(ext_imm);
      ent.err   = ext_err;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_cnt_d = err_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = ent;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (ext_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed steps plus random traffic
// against a queue-based reference model.
module tb_imm_gen_pipe;

   localparam int DATA_W    = 64;
   localparam int DEPTH     = 2;
   localparam int ERR_CNT_W = 8;
`ifdef IMM_BR_SHIFT_EN
   localparam longint BRS = 4;
`else
   localparam longint BRS = 1;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [31:0]          instr = '0;
   logic [2:0]           fmt = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [DATA_W-1:0]    imm;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   imm_gen_pipe #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ERR_CNT_W (ERR_CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .fmt       (fmt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .imm       (imm),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [64:0] q[$];
   int exp_cnt = 0;
   logic last_push;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input longint x, input int w);
      longint m;
      m = x & ((longint'(1) << w) - 1);
      if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
      return m;
   endfunction

   function automatic logic [64:0] ref_ent(input logic [31:0] i,
                                           input logic [2:0] f);
      longint v;
      longint hw;
      logic   e;
      logic [63:0] r;
      e  = 1'b0;
      v  = 0;
      hw = (longint'(i) >> 21) & 3;
      case (f)
         3'd0: v = sx(longint'(i) >> 12, 9);
         3'd1: v = sx(longint'(i) >> 5, 19) * BRS;
         3'd2: v = sx(longint'(i), 26) * BRS;
         3'd3: v = sx(longint'(i) >> 10, 12);
         3'd4: v = (longint'(i) >> 10) & 4095;
         3'd5: begin
            v = ((longint'(i) >> 5) & 65535) * (longint'(1) << (16 * hw));
            if (DATA_W == 32 && hw >= 2) e = 1'b1;
         end
         default: e = 1'b1;
      endcase
      if (e) v = 0;
      r = v;
      if (DATA_W == 32) r = {32'b0, r[31:0]};
      return {r, e};
   endfunction

   // One clock: check visible state at negedge, advance model at posedge.
   task automatic step();
      logic p, o;
      logic [64:0] h;
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      if (q.size() != 0) begin
         h = q[0];
         chk("imm", 64'(imm), h[64:1]);
         chk("out_err", 64'(out_err), 64'(h[0]));
      end
      p = in_valid && (q.size() != DEPTH) && !reset;
      o = (q.size() != 0) && out_ready && !reset;
      @(posedge clk);
      if (reset) begin
         q.delete();
         exp_cnt = 0;
         p = 1'b0;
      end else begin
         h = ref_ent(instr, fmt);
         if (o) void'(q.pop_front());
         if (p) begin
            q.push_back(h);
            if (h[0] && exp_cnt < (1 << ERR_CNT_W) - 1) exp_cnt++;
         end
      end
      last_push = p;
      #1;
   endtask

   task automatic push1(input logic [31:0] i, input logic [2:0] f);
      instr    = i;
      fmt      = f;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      out_ready = 1'b1;
      push1(32'h001FF000, 3'd0);
      chk("daddr9", 64'(imm), 64'hFFFF_FFFF_FFFF_FFFF);
      push1(32'h00800000, 3'd1);
`ifdef IMM_BR_SHIFT_EN
      chk("cond19", 64'(imm), 64'hFFFF_FFFF_FFF0_0000);
`else
      chk("cond19", 64'(imm), 64'hFFFF_FFFF_FFFC_0000);
`endif
      push1(32'h00200000, 3'd3);
      chk("imm12s", 64'(imm), 64'hFFFF_FFFF_FFFF_F800);
      push1(32'h00200000, 3'd4);
      chk("imm12z", 64'(imm), 64'h0000_0000_0000_0800);
      push1(32'h005579A0, 3'd5);
      chk("mov16", 64'(imm), 64'h0000_ABCD_0000_0000);
      for (int k = 0; k < 3; k++) begin
         push1($urandom, 3'd6);
         chk("illegal_imm", 64'(imm), 64'd0);
         chk("illegal_err", 64'(out_err), 64'd1);
      end
      chk("err_cnt3", 64'(err_cnt), 64'd3);
      step();

      // Fill with sink stalled, then stream through with pointer wrap.
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) push1(32'(k + 1) << 10, 3'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      fmt      = 3'd4;
      instr    = 32'h0000_7C00;
      step();
      step();
      chk("full_hold_imm", 64'(imm), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3 * DEPTH + 1; k++) begin
         if (last_push) instr = 32'(k + 10) << 10;
         step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) step();

      // Flush two entries with a reset that also sees a push.
      out_ready = 1'b0;
      push1(32'h0000_0400, 3'd4);
      push1(32'h0000_0800, 3'd6);
      reset    = 1'b1;
      in_valid = 1'b1;
      instr    = 32'h0000_0C00;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_err_cnt", 64'(err_cnt), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();

      // Saturate the illegal counter.
      in_valid = 1'b1;
      fmt      = 3'd7;
      for (int k = 0; k < (1 << ERR_CNT_W) + 4; k++) step();
      in_valid = 1'b0;
      step();
      chk("err_cnt_sat", 64'(err_cnt), 64'((1 << ERR_CNT_W) - 1));

      // Random traffic; held inputs while a push is pending.
      reset = 1'b1;
      step();
      reset     = 1'b0;
      last_push = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (!in_valid || last_push) begin
            in_valid = ($urandom_range(0, 3) != 0);
            instr    = $urandom;
            fmt      = 3'($urandom_range(0, 7));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH + 2; k++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
